ram_window_scanner: RTL

Read-side initiator for the three-read-port 16×8 line RAM. It walks a programmable address range and drives the RAM's three address ports with consecutive addresses (a, a+1, a+2). It absorbs the RAM's one-cycle registered-address read latency and presents each 3-byte window downstream on a valid/ready stream, sustaining one window per cycle when unstalled. It sits between the line RAM and the LCD pixel/filter datapath.

---
 rtl/lcd_ram_pkg.sv | 23 ++
 rtl/ram_window_scanner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lcd_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ram_pkg
// Purpose  : Shared types and defaults for the LCD line-RAM read path
//            (RAM geometry and the window scanner state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package lcd_ram_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;

  // Largest scan length; equals the RAM depth (2**DEFAULT_ADDR_W).
  localparam int MAX_WINDOWS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage : lcd_ram_pkg
`default_nettype wire

// File: rtl/ram_window_scanner.sv
`default_nettype none
// ============================================================================
// Module   : ram_window_scanner
// Purpose  : Walks an address range of the 3-read-port line RAM, driving
//            taps (a, a+1, a+2) and streaming each 3-byte window out on a
//            valid/ready interface at up to one window per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ram_window_scanner
  import lcd_ram_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [ADDR_W-1:0] ram_addr2,
  input  logic [DATA_W-1:0] ram_data0,
  input  logic [DATA_W-1:0] ram_data1,
  input  logic [DATA_W-1:0] ram_data2,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              win_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   C_MAX_N = MAX_WINDOWS[ADDR_W:0];
  localparam logic [ADDR_W:0]   C_INC   = 1;
  localparam logic [ADDR_W-1:0] C_ONE   = 1;
  localparam logic [ADDR_W-1:0] C_TWO   = 2;

  scan_state_t       r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_num;      // clamped window count for this scan
  logic [ADDR_W:0]   r_issued;   // windows fetched so far
  logic              r_pending;  // RAM output holds a fetched, uncaptured window
  logic [ADDR_W-1:0] r_addr0;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;

  logic              w_run;
  logic              w_advance;
  logic              w_load;
  logic              w_issue;
  logic              w_accept;
  logic [ADDR_W-1:0] w_tap0;

  assign w_run     = (r_state == RUN);
  assign w_advance = !win_valid || win_ready;
  assign w_load    = w_run && r_pending && w_advance;
  // A new fetch may only replace pending RAM data if that data is captured
  // this same cycle; otherwise the RAM address register must hold.
  assign w_issue   = w_run && (r_issued < r_num) && (!r_pending || w_advance);
  assign w_accept  = win_valid && win_ready;
  assign w_tap0    = r_base + r_issued[ADDR_W-1:0];

  assign ram_ce    = w_issue;
  assign ram_we    = 1'b0;
  // Addresses show the new fetch while issuing, else the last one issued.
  assign ram_addr0 = w_issue ? w_tap0         : r_addr0;
  assign ram_addr1 = w_issue ? w_tap0 + C_ONE : r_addr1;
  assign ram_addr2 = w_issue ? w_tap0 + C_TWO : r_addr2;

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

  // Scan control, fetch tracking and the registered window stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_num     <= '0;
      r_issued  <= '0;
      r_pending <= 1'b0;
      r_addr0   <= '0;
      r_addr1   <= '0;
      r_addr2   <= '0;
      win0      <= '0;
      win1      <= '0;
      win2      <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base    <= base;
            r_num     <= (count > C_MAX_N) ? C_MAX_N : count;
            r_issued  <= '0;
            r_pending <= 1'b0;
            r_state   <= (count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_issue) begin
            r_issued <= r_issued + C_INC;
            r_addr0  <= w_tap0;
            r_addr1  <= w_tap0 + C_ONE;
            r_addr2  <= w_tap0 + C_TWO;
          end
          r_pending <= w_issue || (r_pending && !w_load);
          if (w_load) begin
            win0      <= ram_data0;
            win1      <= ram_data1;
            win2      <= ram_data2;
            win_valid <= 1'b1;
            // Pending data belongs to window r_issued-1, the last one when
            // every window has already been fetched.
            win_last  <= (r_issued == r_num);
          end else if (w_accept) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
          end
          if (w_accept && win_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : ram_window_scanner
`default_nettype wire
